// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target byte engine: state encoding,
// acknowledge levels and the default target address.
`timescale 1ns/1ps
package i2c_pkg;

    typedef logic [2:0] i2c_state_t;

    localparam i2c_state_t ST_IDLE      = 3'd0;
    localparam i2c_state_t ST_ADDR      = 3'd1;
    localparam i2c_state_t ST_ADDR_ACK  = 3'd2;
    localparam i2c_state_t ST_WR_DATA   = 3'd3;
    localparam i2c_state_t ST_WR_ACK    = 3'd4;
    localparam i2c_state_t ST_RD_DATA   = 3'd5;
    localparam i2c_state_t ST_RD_ACK    = 3'd6;
    localparam i2c_state_t ST_WAIT_STOP = 3'd7;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

    // Open-drain: a 0 data bit pulls the line low, a 1 bit releases it.
    function automatic logic sda_drive_for(input logic data_bit);
        return (data_bit == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one bus line plus a history flop that
// yields single-cycle rise/fall pulses on the synchronised copy.
`timescale 1ns/1ps
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              hist_reg;

    // Shift the raw line through the chain; reset to the idle (pulled-up) level
    // so leaving reset never manufactures an edge on a quiet bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
            hist_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            hist_reg <= sync_reg[STAGES-1];
        end
    end

    assign dout = sync_reg[STAGES-1];
    assign rise = sync_reg[STAGES-1] & ~hist_reg;
    assign fall = ~sync_reg[STAGES-1] & hist_reg;

endmodule

// File: rtl/i2c_slave_shift.sv
// I2C target byte engine: detects START/Sr/STOP, matches a 7-bit address,
// ACKs written bytes, shifts out user bytes on reads. SDA is open-drain.
`timescale 1ns/1ps
module i2c_slave_shift
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i2c_sclk,
    inout  tri         i2c_sda,
    output logic       busy,
    output logic       addr_hit,
    output logic       rw_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       mst_nack,
    output logic       stop_det
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst_n(rst_n), .din(i2c_sclk),
        .dout(scl_s), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst_n(rst_n), .din(i2c_sda),
        .dout(sda_s), .rise(sda_rise), .fall(sda_fall)
    );

    // SDA moving while SCL is steady high is a bus condition; if SCL moves in
    // the same clock it is treated as an ordinary data edge instead.
    logic scl_steady_high;
    logic start_ev, stop_ev;
    assign scl_steady_high = scl_s & ~scl_rise & ~scl_fall;
    assign start_ev        = sda_fall & scl_steady_high;
    assign stop_ev         = sda_rise & scl_steady_high;

    i2c_state_t state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic       byte_rdy_reg, byte_rdy_next;   // 8th bit sampled, act on next SCL fall
    logic [7:0] shift_reg, shift_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       busy_reg, busy_next;
    logic       rw_reg, rw_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       addr_hit_reg, addr_hit_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       tx_req_reg, tx_req_next;
    logic       mst_nack_reg, mst_nack_next;
    logic       stop_det_reg, stop_det_next;

    logic addr_match;
    assign addr_match = (shift_reg[7:1] == SLAVE_ADDR);

    // State and datapath registers; reset releases SDA without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            byte_rdy_reg <= 1'b0;
            shift_reg    <= '0;
            sda_oe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            rw_reg       <= 1'b0;
            rx_data_reg  <= '0;
            addr_hit_reg <= 1'b0;
            rx_valid_reg <= 1'b0;
            tx_req_reg   <= 1'b0;
            mst_nack_reg <= 1'b0;
            stop_det_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_rdy_reg <= byte_rdy_next;
            shift_reg    <= shift_next;
            sda_oe_reg   <= sda_oe_next;
            busy_reg     <= busy_next;
            rw_reg       <= rw_next;
            rx_data_reg  <= rx_data_next;
            addr_hit_reg <= addr_hit_next;
            rx_valid_reg <= rx_valid_next;
            tx_req_reg   <= tx_req_next;
            mst_nack_reg <= mst_nack_next;
            stop_det_reg <= stop_det_next;
        end
    end

    // Next-state logic; STOP and START override whatever the FSM is doing.
    always_comb begin
        state_next = state_reg;
        if (stop_ev) begin
            state_next = ST_IDLE;
        end else if (start_ev) begin
            state_next = ST_ADDR;
        end else begin
            case (state_reg)
                ST_ADDR:     if (scl_fall && byte_rdy_reg)
                                 state_next = addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
                ST_ADDR_ACK: if (scl_fall) state_next = rw_reg ? ST_RD_DATA : ST_WR_DATA;
                ST_WR_DATA:  if (scl_fall && byte_rdy_reg) state_next = ST_WR_ACK;
                ST_WR_ACK:   if (scl_fall) state_next = ST_WR_DATA;
                ST_RD_DATA:  if (scl_fall && bit_cnt_reg == 3'd7) state_next = ST_RD_ACK;
                ST_RD_ACK: begin
                    if (scl_rise && sda_s == I2C_NACK) state_next = ST_WAIT_STOP;
                    else if (scl_fall)                 state_next = ST_RD_DATA;
                end
                default: ;
            endcase
        end
    end

    // Datapath and output pulses; SDA only changes on SCL falling edges.
    always_comb begin
        bit_cnt_next  = bit_cnt_reg;
        byte_rdy_next = byte_rdy_reg;
        shift_next    = shift_reg;
        sda_oe_next   = sda_oe_reg;
        busy_next     = busy_reg;
        rw_next       = rw_reg;
        rx_data_next  = rx_data_reg;
        addr_hit_next = 1'b0;
        rx_valid_next = 1'b0;
        tx_req_next   = 1'b0;
        mst_nack_next = 1'b0;
        stop_det_next = 1'b0;
        if (stop_ev) begin
            sda_oe_next   = 1'b0;
            busy_next     = 1'b0;
            stop_det_next = 1'b1;
            bit_cnt_next  = '0;
            byte_rdy_next = 1'b0;
        end else if (start_ev) begin
            sda_oe_next   = 1'b0;
            busy_next     = 1'b1;
            bit_cnt_next  = '0;
            byte_rdy_next = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_next    = {shift_reg[6:0], sda_s};
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        byte_rdy_next = (bit_cnt_reg == 3'd7);
                    end else if (scl_fall && byte_rdy_reg) begin
                        byte_rdy_next = 1'b0;
                        if (state_reg == ST_ADDR) begin
                            if (addr_match) begin
                                addr_hit_next = 1'b1;
                                rw_next       = shift_reg[0];
                                tx_req_next   = shift_reg[0];
                                sda_oe_next   = 1'b1;
                            end
                        end else begin
                            rx_data_next  = shift_reg;
                            rx_valid_next = 1'b1;
                            sda_oe_next   = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = '0;
                        if (rw_reg) begin
                            shift_next  = tx_data;
                            sda_oe_next = sda_drive_for(tx_data[7]);
                        end else begin
                            sda_oe_next = 1'b0;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) sda_oe_next = 1'b0;
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            sda_oe_next = 1'b0;
                        end else begin
                            shift_next  = {shift_reg[6:0], 1'b0};
                            sda_oe_next = sda_drive_for(shift_reg[6]);
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) tx_req_next   = 1'b1;
                        else                  mst_nack_next = 1'b1;
                    end else if (scl_fall) begin
                        shift_next   = tx_data;
                        sda_oe_next  = sda_drive_for(tx_data[7]);
                        bit_cnt_next = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_sda  = sda_oe_reg ? 1'b0 : 1'bz;
    assign busy     = busy_reg;
    assign addr_hit = addr_hit_reg;
    assign rw_o     = rw_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign tx_req   = tx_req_reg;
    assign mst_nack = mst_nack_reg;
    assign stop_det = stop_det_reg;

endmodule

// File: tb/tb_i2c_slave_shift.sv
// Directed bench for i2c_slave_shift: a bit-banged master drives SCL/SDA,
// pulse counters watch the target's outputs.
`timescale 1ns/1ps
module tb_i2c_slave_shift;

    localparam int Q = 10;   // quarter SCL period in system clocks

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       scl      = 1'b1;
    logic       m_sda_oe = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    tri         sda_bus;

    logic       busy, addr_hit, rw_o, rx_valid, tx_req, mst_nack, stop_det;
    logic [7:0] rx_data;

    always #10 clk = ~clk;

    assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_shift #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .i2c_sclk(scl), .i2c_sda(sda_bus),
        .busy(busy), .addr_hit(addr_hit), .rw_o(rw_o), .rx_data(rx_data),
        .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
        .mst_nack(mst_nack), .stop_det(stop_det)
    );

    // User side: hand out the next table byte on each tx_req.
    logic [7:0] tx_tab [8] = '{8'h3C, 8'hC3, 8'h96, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    int tx_idx = 0;
    always @(negedge clk) begin
        if (tx_req) begin
            tx_data = tx_tab[tx_idx % 8];
            tx_idx  = tx_idx + 1;
        end
    end

    // Pulse counters and count of cycles where the target pulls SDA low.
    int n_hit = 0, n_rxv = 0, n_txr = 0, n_nack = 0, n_stop = 0, n_slow = 0;
    always @(negedge clk) begin
        if (addr_hit) n_hit++;
        if (rx_valid) n_rxv++;
        if (tx_req)   n_txr++;
        if (mst_nack) n_nack++;
        if (stop_det) n_stop++;
        if (!m_sda_oe && sda_bus == 1'b0) n_slow++;
    end

    int b_hit, b_rxv, b_txr, b_nack, b_stop, b_slow;
    task automatic snap();
        b_hit = n_hit; b_rxv = n_rxv; b_txr = n_txr;
        b_nack = n_nack; b_stop = n_stop; b_slow = n_slow;
    endtask

    int n_checks = 0;
    int n_fail   = 0;
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_oe = 1'b0; scl = 1'b1; wq();
        m_sda_oe = 1'b1; wq();
        scl = 1'b0; wq();
    endtask

    task automatic bus_rstart();
        m_sda_oe = 1'b0; wq();
        scl = 1'b1; wq();
        m_sda_oe = 1'b1; wq();
        scl = 1'b0; wq();
    endtask

    task automatic bus_stop();
        m_sda_oe = 1'b1; wq();
        scl = 1'b1; wq();
        m_sda_oe = 1'b0; wq(); wq();
    endtask

    task automatic bus_bit(input logic b, output logic r);
        m_sda_oe = !b; wq();
        scl = 1'b1; wq();
        r = sda_bus; wq();
        scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(nack, r);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       a0, a1, a2;
        logic [7:0] d0, d1;

        // Reset
        repeat (3) @(negedge clk);
        check_eq("rst_sda", sda_bus, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rx_valid", rx_valid, 1'b0);
        check_eq("rst_rw_o", rw_o, 1'b0);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_addr_hit", addr_hit, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write 0xA5 to 0x50
        snap();
        bus_start();
        check_eq("wr_busy_mid", busy, 1'b1);
        write_byte(8'hA0, a0);
        write_byte(8'hA5, a1);
        bus_stop();
        check_eq("wr_addr_ack", a0, 1'b0);
        check_eq("wr_data_ack", a1, 1'b0);
        check_eq("wr_hit", n_hit - b_hit, 1);
        check_eq("wr_rw_o", rw_o, 1'b0);
        check_eq("wr_rx_data", rx_data, 8'hA5);
        check_eq("wr_rx_valid", n_rxv - b_rxv, 1);
        check_eq("wr_stop", n_stop - b_stop, 1);
        check_eq("wr_busy_end", busy, 1'b0);
        $display("txn write: addr_ack=%0d data_ack=%0d rx_data=0x%02h", a0, a1, rx_data);

        // Address mismatch
        snap();
        bus_start();
        write_byte(8'hA2, a0);
        write_byte(8'h12, a1);
        bus_stop();
        check_eq("mm_addr_ack", a0, 1'b1);
        check_eq("mm_data_ack", a1, 1'b1);
        check_eq("mm_hit", n_hit - b_hit, 0);
        check_eq("mm_rx_valid", n_rxv - b_rxv, 0);
        check_eq("mm_slave_low", n_slow - b_slow, 0);
        check_eq("mm_stop", n_stop - b_stop, 1);
        $display("txn mismatch: addr_ack=%0d data_ack=%0d", a0, a1);

        // Read two bytes, ACK then NACK
        snap();
        bus_start();
        write_byte(8'hA1, a0);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        bus_stop();
        check_eq("rd_addr_ack", a0, 1'b0);
        check_eq("rd_byte0", d0, 8'h3C);
        check_eq("rd_byte1", d1, 8'hC3);
        check_eq("rd_tx_req", n_txr - b_txr, 2);
        check_eq("rd_nack", n_nack - b_nack, 1);
        check_eq("rd_stop", n_stop - b_stop, 1);
        check_eq("rd_busy_end", busy, 1'b0);
        $display("txn read: byte0=0x%02h byte1=0x%02h", d0, d1);

        // Write 0x01, repeated START, read one byte
        snap();
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'h01, a1);
        check_eq("sr_rx_data", rx_data, 8'h01);
        check_eq("sr_rw_before", rw_o, 1'b0);
        b_slow = n_slow;
        bus_rstart();
        check_eq("sr_released", n_slow - b_slow, 0);
        write_byte(8'hA1, a2);
        check_eq("sr_rw_after", rw_o, 1'b1);
        read_byte(1'b1, d0);
        bus_stop();
        check_eq("sr_acks", {a0, a1, a2}, 3'b000);
        check_eq("sr_read", d0, 8'h96);
        check_eq("sr_hit", n_hit - b_hit, 2);
        check_eq("sr_nack", n_nack - b_nack, 1);
        check_eq("sr_rx_valid", n_rxv - b_rxv, 1);
        $display("txn repeated-start: rx_data=0x%02h read=0x%02h rw_o=%0d", rx_data, d0, rw_o);

        // STOP after 4 data bits, then a normal write
        snap();
        bus_start();
        write_byte(8'hA0, a0);
        bus_bit(1'b1, a1); bus_bit(1'b0, a1); bus_bit(1'b1, a1); bus_bit(1'b1, a1);
        bus_stop();
        check_eq("ab_busy", busy, 1'b0);
        check_eq("ab_rx_valid", n_rxv - b_rxv, 0);
        check_eq("ab_rx_data", rx_data, 8'h01);
        check_eq("ab_stop", n_stop - b_stop, 1);
        snap();
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'h5A, a1);
        bus_stop();
        check_eq("ab_next_acks", {a0, a1}, 2'b00);
        check_eq("ab_next_rx", rx_data, 8'h5A);
        check_eq("ab_next_valid", n_rxv - b_rxv, 1);
        $display("txn abort: then rx_data=0x%02h", rx_data);

        // Reset while driving a 0 read bit
        bus_start();
        write_byte(8'hA1, a0);
        repeat (2) @(negedge clk);
        check_eq("rr_addr_ack", a0, 1'b0);
        check_eq("rr_driving", sda_bus, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("rr_released", sda_bus, 1'b1);
        check_eq("rr_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        snap();
        for (int i = 0; i < 9; i++) bus_bit(1'b1, a1);
        check_eq("rr_no_drive", n_slow - b_slow, 0);
        check_eq("rr_no_hit", n_hit - b_hit, 0);
        bus_stop();
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'h77, a1);
        bus_stop();
        check_eq("rr_fresh_acks", {a0, a1}, 2'b00);
        check_eq("rr_fresh_rx", rx_data, 8'h77);
        $display("txn reset-mid-read: fresh rx_data=0x%02h", rx_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
